ghost_move_sequencer: RTL and testbench
=======================================

// Module: ghost_move_sequencer
// PURPOSE
//  Drives one ghost target-selection core: owns ghost position and facing, produces the update strobe,
//  the mode word (chase/scatter/frightened/eaten) and the reversal flag, and commits the core's returned
//  nextloc/nextfacing. Runs the scatter/chase wave schedule plus frightened/eaten overrides. One instance
//  per ghost, between the game-tick source and the ghost core.
// PARAMETERS
//  START_LOC        16'h6C60  reset position {x[15:8], y[7:0]}
//  START_FACING     16'hFF00  reset facing (LEFT)
//  HOME_LOC         16'h6C60  ghost-house cell; reaching it ends Eaten
//  STEP_TICKS       4         ticks per move in Scatter/Chase
//  FRIGHT_STEP      8         ticks per move in Frightened
//  EATEN_STEP       1         ticks per move in Eaten
//  SCATTER_TICKS    70        ticks per scatter wave
//  CHASE_TICKS      200       ticks per chase wave
//  FRIGHT_TICKS     60        frightened duration in ticks
//  NUM_WAVES        4         scatter waves; then chase forever
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  tick           in   1   one-cycle game-tick pulse
//  enable         in   1   0 = freeze move and mode timers (pause)
//  energizer      in   1   one-cycle pulse: Pac-Man ate power pellet
//  ghost_eaten    in   1   one-cycle pulse: collision while Frightened
//  nextloc        in   16  core result location (valid after update falls)
//  nextfacing     in   16  core result facing (LEFT FF00/RIGHT 0100/UP 00FF/DOWN 0001)
//  update         out  1   strobe to core; high exactly 2 cycles per move
//  mode           out  4   one-hot: Chase 1000, Scatter 0100, Frightened 0010, Eaten 0001
//  rotate         out  1   reverse-direction request for next move
//  currentloc     out  16  committed ghost location
//  currentfacing  out  16  committed ghost facing
//  move_done      out  1   one-cycle pulse on each commit
// BEHAVIOUR
//  Reset: update=0, rotate=0, move_done=0, mode=Scatter, currentloc=START_LOC, currentfacing=START_FACING;
//   all counters 0, wave=0, no pending mode. Reset mid-move aborts the move, no commit.
//  Move FSM: IDLE -> UPD1 -> UPD2 -> SETTLE -> COMMIT -> IDLE, one cycle each (except IDLE).
//   IDLE: step counter counts enabled ticks; at step limit for current mode (STEP_TICKS/FRIGHT_STEP/
//   EATEN_STEP) clear counter, go UPD1. UPD1,UPD2: update=1. SETTLE: update=0 (core resolves on fall).
//   COMMIT: currentloc<=nextloc, currentfacing<=nextfacing, move_done=1, rotate<=0.
//   Move latency: 4 cycles from trigger tick to commit. Ticks during UPD1..COMMIT not counted.
//   enable=0 holds FSM in IDLE (an in-flight move still completes); timers hold value.
//  Mode scheduler (counts enabled ticks):
//   Scatter for SCATTER_TICKS then Chase for CHASE_TICKS, wave++ on each Chase entry; after NUM_WAVES
//   scatter waves, Chase permanently. Wave timer paused while Frightened or Eaten.
//   energizer in Scatter/Chase: Frightened, fright timer=FRIGHT_TICKS. energizer in Frightened: restart
//   fright timer only. energizer in Eaten: ignored. Fright timer expiry: resume paused wave mode.
//   ghost_eaten in Frightened: Eaten (fright cancelled); ignored in other modes.
//   Eaten ends at a COMMIT where nextloc==HOME_LOC: resume paused wave mode.
//   Same cycle energizer and ghost_eaten while Frightened: ghost_eaten wins.
//  Mode output stability: mode changes only while FSM in IDLE; change requested in UPD1..COMMIT is
//   latched pending and applied the first IDLE cycle; later requests overwrite pending one.
//  rotate set on applied transitions Scatter<->Chase and Scatter/Chase->Frightened; never on Eaten entry
//   or exit, nor Frightened->wave; held until next COMMIT. Set and COMMIT same cycle: set wins.
//  Timer widths: 8-bit counters; parameters must be 1..255. Step limit change mid-count: compare to
//   new limit; count>=limit triggers immediately.
// TESTING
//  reset, STEP_TICKS=4, 4 ticks -> update high 2 cycles, commit 2 cycles after fall; currentloc=nextloc.
//  SCATTER_TICKS=3, CHASE_TICKS=5: 3 ticks -> mode 1000, rotate=1 through next commit, then 0.
//  energizer in Chase -> mode 0010, rotate=1, moves every 8 ticks; 60 ticks later mode 1000, rotate=0.
//  ghost_eaten in Frightened, nextloc=HOME_LOC on 3rd move -> mode 0001 for 3 moves, then wave mode.
//  energizer during UPD2 -> mode stays until IDLE, then 0010; update never glitches.
//  NUM_WAVES=1 -> after one scatter+chase cycle mode stays 1000 indefinitely; reset mid-UPD1 -> update=0.

Source files
------------

// File: rtl/ghost_move_sequencer.sv
// Per-ghost move sequencer: paces moves on game ticks, strobes the target core, commits its result.
// Move latency 4 cycles from trigger tick to commit; mode changes are deferred until the move FSM is idle.
module ghost_move_sequencer #(
  parameter logic [15:0] START_LOC     = 16'h6C60,
  parameter logic [15:0] START_FACING  = 16'hFF00,
  parameter logic [15:0] HOME_LOC      = 16'h6C60,
  parameter int unsigned STEP_TICKS    = 4,
  parameter int unsigned FRIGHT_STEP   = 8,
  parameter int unsigned EATEN_STEP    = 1,
  parameter int unsigned SCATTER_TICKS = 70,
  parameter int unsigned CHASE_TICKS   = 200,
  parameter int unsigned FRIGHT_TICKS  = 60,
  parameter int unsigned NUM_WAVES     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        enable,
  input  logic        energizer,
  input  logic        ghost_eaten,
  input  logic [15:0] nextloc,
  input  logic [15:0] nextfacing,
  output logic        update,
  output logic [3:0]  mode,
  output logic        rotate,
  output logic [15:0] currentloc,
  output logic [15:0] currentfacing,
  output logic        move_done
);

  localparam logic [7:0] STEP_L   = 8'(STEP_TICKS);
  localparam logic [7:0] FSTEP_L  = 8'(FRIGHT_STEP);
  localparam logic [7:0] ESTEP_L  = 8'(EATEN_STEP);
  localparam logic [7:0] SCAT_L   = 8'(SCATTER_TICKS);
  localparam logic [7:0] CHASE_L  = 8'(CHASE_TICKS);
  localparam logic [7:0] FRIGHT_L = 8'(FRIGHT_TICKS);
  localparam logic [7:0] WAVES_L  = 8'(NUM_WAVES);

  localparam logic [3:0] M_CHASE   = 4'b1000;
  localparam logic [3:0] M_SCATTER = 4'b0100;
  localparam logic [3:0] M_FRIGHT  = 4'b0010;
  localparam logic [3:0] M_EATEN   = 4'b0001;

  localparam logic [1:0] OVR_NONE   = 2'd0;
  localparam logic [1:0] OVR_FRIGHT = 2'd1;
  localparam logic [1:0] OVR_EATEN  = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_UPD1, S_UPD2, S_SETTLE, S_COMMIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  step_q, step_d, step_inc, step_lim;
  logic [7:0]  wcnt_q, wcnt_d, fcnt_q, fcnt_d, wave_q, wave_d;
  logic        chase_q, chase_d;
  logic [1:0]  ovr_q, ovr_d;
  logic [3:0]  mode_q, mode_d, tgt_mode;
  logic        rotate_q, rotate_d, rot_set, tick_en;
  logic [15:0] loc_q, loc_d, facing_q, facing_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Step limit follows the applied mode; a lowered limit fires at once if already reached.
  always_comb begin
    case (mode_q)
      M_FRIGHT: step_lim = FSTEP_L;
      M_EATEN:  step_lim = ESTEP_L;
      default:  step_lim = STEP_L;
    endcase
    step_inc = step_q + {7'd0, tick};
    state_d  = state_q;
    step_d   = step_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          if (step_inc >= step_lim) begin
            step_d  = '0;
            state_d = S_UPD1;
          end else begin
            step_d = step_inc;
          end
        end
      end
      S_UPD1:   state_d = S_UPD2;
      S_UPD2:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    update    = (state_q == S_UPD1) || (state_q == S_UPD2);
    move_done = (state_q == S_COMMIT);
  end

  always_comb begin
    chase_d = chase_q;
    ovr_d   = ovr_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    wave_d  = wave_q;
    tick_en = tick & enable;
    if (ovr_q == OVR_NONE && tick_en) begin
      if (!chase_q) begin
        if (wcnt_q + 8'd1 >= SCAT_L) begin
          chase_d = 1'b1;
          wcnt_d  = '0;
          wave_d  = wave_q + 8'd1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end else if (wave_q < WAVES_L) begin
        if (wcnt_q + 8'd1 >= CHASE_L) begin
          chase_d = 1'b0;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
    end else if (ovr_q == OVR_FRIGHT && tick_en) begin
      if (fcnt_q + 8'd1 >= FRIGHT_L) begin
        ovr_d  = OVR_NONE;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
    if (ovr_q == OVR_FRIGHT && ghost_eaten) begin
      ovr_d  = OVR_EATEN;
      fcnt_d = '0;
    end else if (energizer && ovr_q != OVR_EATEN) begin
      ovr_d  = OVR_FRIGHT;
      fcnt_d = '0;
    end
    if (ovr_q == OVR_EATEN && state_q == S_COMMIT && nextloc == HOME_LOC) ovr_d = OVR_NONE;
  end

  // The scheduler's target mode is only exposed on cycles the FSM is idle; otherwise it waits as pending.
  always_comb begin
    case (ovr_d)
      OVR_FRIGHT: tgt_mode = M_FRIGHT;
      OVR_EATEN:  tgt_mode = M_EATEN;
      default:    tgt_mode = chase_d ? M_CHASE : M_SCATTER;
    endcase
    mode_d   = (state_d == S_IDLE) ? tgt_mode : mode_q;
    rot_set  = (mode_d != mode_q) && (mode_q == M_CHASE || mode_q == M_SCATTER) && (mode_d != M_EATEN);
    rotate_d = rot_set ? 1'b1 : ((state_q == S_COMMIT) ? 1'b0 : rotate_q);
    loc_d    = (state_q == S_COMMIT) ? nextloc : loc_q;
    facing_d = (state_q == S_COMMIT) ? nextfacing : facing_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chase_q  <= 1'b0;
      ovr_q    <= OVR_NONE;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      wave_q   <= '0;
      mode_q   <= M_SCATTER;
      rotate_q <= 1'b0;
      loc_q    <= START_LOC;
      facing_q <= START_FACING;
    end else begin
      chase_q  <= chase_d;
      ovr_q    <= ovr_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      wave_q   <= wave_d;
      mode_q   <= mode_d;
      rotate_q <= rotate_d;
      loc_q    <= loc_d;
      facing_q <= facing_d;
    end
  end

  assign mode          = mode_q;
  assign rotate        = rotate_q;
  assign currentloc    = loc_q;
  assign currentfacing = facing_q;

endmodule

// File: tb/tb_ghost_move_sequencer.sv
// Directed bench for ghost_move_sequencer: cycle table for the first moves and wave flips,
// then hand sequences for fright, eaten, pending mode changes, pause and mid-move reset.
module tb_ghost_move_sequencer;

  logic        clock, reset, tick, enable, energizer, ghost_eaten;
  logic [15:0] nextloc, nextfacing;
  logic        update, rotate, move_done;
  logic [3:0]  mode;
  logic [15:0] currentloc, currentfacing;

  int n_total = 0;
  int n_pass  = 0;
  int moves   = 0;
  int m0;

  typedef struct {
    logic        tick;
    logic        upd;
    logic [3:0]  mode;
    logic        rot;
    logic        md;
    logic [15:0] loc;
  } row_t;

  row_t vec [18];

  ghost_move_sequencer #(
    .STEP_TICKS(4), .FRIGHT_STEP(8), .EATEN_STEP(1),
    .SCATTER_TICKS(3), .CHASE_TICKS(5), .FRIGHT_TICKS(60), .NUM_WAVES(2)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .enable(enable),
    .energizer(energizer), .ghost_eaten(ghost_eaten),
    .nextloc(nextloc), .nextfacing(nextfacing),
    .update(update), .mode(mode), .rotate(rotate),
    .currentloc(currentloc), .currentfacing(currentfacing), .move_done(move_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (move_done === 1'b1) moves++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_row(input int i, input logic t, input logic u, input logic [3:0] m,
                         input logic r, input logic d, input logic [15:0] l);
    vec[i].tick = t; vec[i].upd = u; vec[i].mode = m;
    vec[i].rot = r;  vec[i].md = d;  vec[i].loc = l;
  endtask

  // One tick pulse followed by enough idle cycles for any move it starts to commit.
  task automatic do_tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock); tick = 1'b1;
      @(negedge clock); tick = 1'b0;
      repeat (5) @(negedge clock);
    end
  endtask

  initial begin
    set_row(0,  1, 0, 4'b0100, 0, 0, 16'h6C60);
    set_row(1,  0, 0, 4'b0100, 0, 0, 16'h6C60);
    set_row(2,  1, 0, 4'b0100, 0, 0, 16'h6C60);
    set_row(3,  0, 0, 4'b0100, 0, 0, 16'h6C60);
    set_row(4,  1, 0, 4'b1000, 1, 0, 16'h6C60);
    set_row(5,  1, 1, 4'b1000, 1, 0, 16'h6C60);
    set_row(6,  1, 1, 4'b1000, 1, 0, 16'h6C60);
    set_row(7,  0, 0, 4'b1000, 1, 0, 16'h6C60);
    set_row(8,  0, 0, 4'b1000, 1, 1, 16'h6C60);
    set_row(9,  0, 0, 4'b1000, 0, 0, 16'h1234);
    set_row(10, 1, 0, 4'b1000, 0, 0, 16'h1234);
    set_row(11, 1, 0, 4'b1000, 0, 0, 16'h1234);
    set_row(12, 1, 0, 4'b0100, 1, 0, 16'h1234);
    set_row(13, 1, 1, 4'b0100, 1, 0, 16'h1234);
    set_row(14, 0, 1, 4'b0100, 1, 0, 16'h1234);
    set_row(15, 0, 0, 4'b0100, 1, 0, 16'h1234);
    set_row(16, 0, 0, 4'b0100, 1, 1, 16'h1234);
    set_row(17, 0, 0, 4'b0100, 0, 0, 16'h1234);

    reset = 1'b1; tick = 1'b0; enable = 1'b1; energizer = 1'b0; ghost_eaten = 1'b0;
    nextloc = 16'h1234; nextfacing = 16'h0100;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_update", {15'd0, update}, 16'd0);
    chk("rst_rotate", {15'd0, rotate}, 16'd0);
    chk("rst_move_done", {15'd0, move_done}, 16'd0);
    chk("rst_mode", {12'd0, mode}, 16'h0004);
    chk("rst_loc", currentloc, 16'h6C60);
    chk("rst_facing", currentfacing, 16'hFF00);
    @(negedge clock); reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clock); tick = vec[i].tick;
      @(posedge clock); #1;
      chk($sformatf("row%0d_update", i), {15'd0, update}, {15'd0, vec[i].upd});
      chk($sformatf("row%0d_mode", i), {12'd0, mode}, {12'd0, vec[i].mode});
      chk($sformatf("row%0d_rotate", i), {15'd0, rotate}, {15'd0, vec[i].rot});
      chk($sformatf("row%0d_move_done", i), {15'd0, move_done}, {15'd0, vec[i].md});
      chk($sformatf("row%0d_loc", i), currentloc, vec[i].loc);
    end
    chk("table_facing", currentfacing, 16'h0100);
    @(negedge clock); tick = 1'b0;

    // Second scatter wave ends; with two waves done chase must persist.
    do_tick(2);
    chk("wave2_chase_mode", {12'd0, mode}, 16'h0008);
    chk("wave2_chase_rotate", {15'd0, rotate}, 16'd1);
    m0 = moves;
    do_tick(20);
    chk("perm_chase_moves", 16'(moves - m0), 16'd5);
    chk("perm_chase_mode", {12'd0, mode}, 16'h0008);
    chk("perm_chase_rotate", {15'd0, rotate}, 16'd0);

    // Energizer in chase: frightened, slower step, 60-tick duration.
    @(negedge clock); energizer = 1'b1;
    @(posedge clock); #1;
    chk("fright_mode", {12'd0, mode}, 16'h0002);
    chk("fright_rotate", {15'd0, rotate}, 16'd1);
    @(negedge clock); energizer = 1'b0;
    m0 = moves;
    do_tick(5);
    chk("fright_no_move_yet", 16'(moves - m0), 16'd0);
    do_tick(1);
    chk("fright_first_move", 16'(moves - m0), 16'd1);
    chk("fright_rotate_cleared", {15'd0, rotate}, 16'd0);
    m0 = moves;
    do_tick(53);
    chk("fright_moves_53", 16'(moves - m0), 16'd6);
    chk("fright_still", {12'd0, mode}, 16'h0002);
    m0 = moves;
    do_tick(1);
    chk("fright_expired_mode", {12'd0, mode}, 16'h0008);
    chk("fright_expired_rotate", {15'd0, rotate}, 16'd0);
    chk("limit_drop_immediate_move", 16'(moves - m0), 16'd1);

    // Energizer arriving mid-move stays pending until idle.
    do_tick(3);
    @(negedge clock); tick = 1'b1;
    @(posedge clock); #1;
    chk("pend_upd1_update", {15'd0, update}, 16'd1);
    @(negedge clock); tick = 1'b0;
    @(posedge clock); #1;
    chk("pend_upd2_update", {15'd0, update}, 16'd1);
    @(negedge clock); energizer = 1'b1;
    @(posedge clock); #1;
    chk("pend_settle_update", {15'd0, update}, 16'd0);
    chk("pend_settle_mode", {12'd0, mode}, 16'h0008);
    @(negedge clock); energizer = 1'b0;
    @(posedge clock); #1;
    chk("pend_commit_move_done", {15'd0, move_done}, 16'd1);
    chk("pend_commit_mode", {12'd0, mode}, 16'h0008);
    @(posedge clock); #1;
    chk("pend_applied_mode", {12'd0, mode}, 16'h0002);
    chk("pend_applied_rotate", {15'd0, rotate}, 16'd1);

    // ghost_eaten beats a simultaneous energizer; eaten runs until a commit at home.
    @(negedge clock); energizer = 1'b1; ghost_eaten = 1'b1;
    @(posedge clock); #1;
    chk("eaten_mode", {12'd0, mode}, 16'h0001);
    chk("eaten_rotate_held", {15'd0, rotate}, 16'd1);
    @(negedge clock); energizer = 1'b0; ghost_eaten = 1'b0;
    m0 = moves;
    do_tick(2);
    chk("eaten_two_moves", 16'(moves - m0), 16'd2);
    chk("eaten_mode_held", {12'd0, mode}, 16'h0001);
    chk("eaten_rotate_cleared", {15'd0, rotate}, 16'd0);
    nextloc = 16'h6C60;
    do_tick(1);
    chk("eaten_home_moves", 16'(moves - m0), 16'd3);
    chk("eaten_exit_mode", {12'd0, mode}, 16'h0008);
    chk("eaten_exit_rotate", {15'd0, rotate}, 16'd0);
    chk("eaten_home_loc", currentloc, 16'h6C60);

    // Pause freezes the move timer.
    enable = 1'b0; nextloc = 16'h1234;
    m0 = moves;
    do_tick(10);
    chk("pause_no_moves", 16'(moves - m0), 16'd0);
    enable = 1'b1;
    do_tick(3);
    chk("resume_partial", 16'(moves - m0), 16'd0);
    do_tick(1);
    chk("resume_move", 16'(moves - m0), 16'd1);
    chk("resume_loc", currentloc, 16'h1234);

    // Reset during UPD1 aborts the move.
    nextloc = 16'hABCD;
    do_tick(3);
    @(negedge clock); tick = 1'b1;
    @(posedge clock); #1;
    chk("abort_upd1_update", {15'd0, update}, 16'd1);
    @(negedge clock); tick = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_update", {15'd0, update}, 16'd0);
    chk("abort_mode", {12'd0, mode}, 16'h0004);
    chk("abort_facing", currentfacing, 16'hFF00);
    @(negedge clock); reset = 1'b0;
    m0 = moves;
    repeat (6) @(negedge clock);
    chk("abort_no_commit", 16'(moves - m0), 16'd0);
    chk("abort_loc", currentloc, 16'h6C60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
